controle_pipeline: RTL and testbench
====================================

# controle_pipeline

Parametrised, registered successor to the combinational main decoder of the RV32 reduced-ISA pipeline. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers, each with a valid bit. It also detects load-use hazards, inserts bubbles on hazard, illegal opcode or branch flush, freezes on an external stall, and counts stall cycles. It sits between the IF/ID register and the datapath stage registers, which consume its `ex_*`, `mem_*` and `wb_*` outputs directly.

## Interface
Parameters:
- `EXT_OPS`, 1: when 1, LUI (0110111) and AUIPC (0010111) are legal; when 0, they decode as illegal.
- `LOADUSE_DETECT`, 1: when 0, `hazard_stall` is tied to 0 (the compiler schedules around load-use).
- `CNTW`, 16: width of the saturating stall counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `id_valid` in 1: the IF/ID register holds a real instruction.
- `id_opcode` in 7: instr[6:0].
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register fields.
- `stall_ext` in 1: memory or other external wait; freezes all control registers.
- `flush_ex` in 1: the branch/jump in EX is resolved as redirecting; kills the instruction in ID.
- `hazard_stall` out 1: combinational; holds PC and IF/ID.
- `id_illegal` out 1: combinational; `id_valid` is high with an unrecognised opcode.
- `ex_valid` out 1, `ex_alusrc` out 1, `ex_alusrc_a` out 1, `ex_aluop` out 2, `ex_rd` out 5.
- `mem_valid` out 1, `mem_memread` out 1, `mem_memwrite` out 1, `mem_branch` out 2, `mem_rd` out 5.
- `wb_valid` out 1, `wb_regwrite` out 1, `wb_mem2reg` out 2, `wb_rd` out 5.
- `stall_count` out `CNTW`: number of cycles in which `hazard_stall` or `stall_ext` was high, saturating.

## Operation
Decode is combinational in ID. There are no x outputs anywhere.

Per opcode, the bundle fields are ALUSrc / ALUSrcA / ALUOp / MemRead / MemWrite / Branch / RegWrite / Mem2Reg / uses_rs1 / uses_rs2:
- R 0110011: 0/0/10/0/0/BCN/1/REGALU/1/1.
- LOAD 0000011: 1/0/00/1/0/BCN/1/REGMEM/1/0.
- STORE 0100011: 1/0/00/0/1/BCN/0/REGALU/1/1.
- BRANCH 1100011: 0/0/01/0/0/BCB/0/REGALU/1/1.
- OP-IMM 0010011: 1/0/11/0/0/BCN/1/REGALU/1/0.
- JALR 1100111: 1/0/00/0/0/BCJALR/1/RPC/1/0.
- JAL 1101111: 0/0/00/0/0/BCJAL/1/RPC/0/0.
- LUI: 1/0/00/0/0/BCN/1/REGIMM/0/0.
- AUIPC: 1/1/00/0/0/BCN/1/REGALU/0/0.

Encodings:
- ALUOp: 00 = add, 01 = subtract/compare, 10 = R-type funct decode, 11 = I-type funct decode.
- Mem2Reg: REGALU 00, REGMEM 01, RPC 10, REGIMM 11.
- Branch: BCN 00, BCB 01, BCJAL 10, BCJALR 11.

Illegal opcode, or `id_valid` = 0: the bundle is all zeros (a bubble). `id_illegal` is high only when `id_valid` is 1.

Load-use hazard:
- Condition: `ex_valid & ex_memread & ex_rd != 0`, and either (`ex_rd == id_rs1` and uses_rs1) or (`ex_rd == id_rs2` and uses_rs2), and `id_valid`.
- `hazard_stall` is this condition gated by `!flush_ex` and `LOADUSE_DETECT`.

ID/EX update, in priority order:
1. `!rst_n`: all registers 0.
2. `stall_ext`: all three stages hold.
3. `flush_ex` or `hazard_stall` or `id_illegal`: ID/EX loads a bubble (valid 0, all controls 0, rd 0).
4. Otherwise: ID/EX loads the decoded bundle, with valid = `id_valid`.

EX/MEM and MEM/WB shift every cycle unless `stall_ext` is high. A stage's controls are meaningful only when its valid bit is 1. Bubbles always carry zero controls, so `wb_regwrite` and `mem_memwrite` are never high for an invalid slot.

`stall_count`:
- Increments in any cycle with (`hazard_stall | stall_ext`).
- Saturates at 2^CNTW − 1.
- Cleared only by reset.

## Timing
- Reset value of every registered output is 0, including `stall_count`.
- `hazard_stall` and `id_illegal` are combinational from inputs and EX registers. They are 0 during reset only if `id_valid` is 0.
- Latency: an instruction decoded in cycle N appears on `ex_*` at N+1, `mem_*` at N+2 and `wb_*` at N+3, each plus any `stall_ext` cycles.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM, so the condition clears.
- `flush_ex` together with a hazard: the flush wins, `hazard_stall` = 0, and a single bubble is inserted.
- `stall_ext` together with `flush_ex`: the hold wins. The flush must be reasserted by the source while the branch stays in EX.
- Reset mid-operation clears all stages within one edge. No partial state survives.

## Structure
- Opcode constants, Mem2Reg/Branch/ALUOp encodings and the control-bundle struct go in the shared package, extending the existing constants with REGIMM, LUI and AUIPC.
- One sub-module is natural: `controle_decode`, the pure combinational opcode-to-bundle decoder plus `uses_rs1`/`uses_rs2` and illegal detection.
- The registers, hazard logic and counter stay in the top.

## Test plan
- Stream R, LOAD, STORE, BRANCH, OP-IMM, JALR and JAL, one per cycle, with `id_valid` = 1. Each bundle appears on `ex_*` at N+1, `mem_*` at N+2 and `wb_*` at N+3. Check R gives `ex_aluop` = 10, LOAD gives `wb_mem2reg` = 01, and JAL gives `mem_branch` = 10.
- `lw x5` followed by `add x6,x5,x1`. Expect `hazard_stall` = 1 for exactly 1 cycle, `ex_valid` = 0 the next cycle, the add in EX one cycle later, and `stall_count` = 1.
- `lw x0` followed by `add x6,x0,x1`, and `lw x5` followed by `jal`. Expect no stall in either case.
- Opcode 0000000 with `id_valid` = 1. Expect `id_illegal` = 1 and a bubble in EX. With `EXT_OPS` = 0, LUI behaves the same way.
- Load-use condition present and `flush_ex` = 1 in the same cycle. Expect `hazard_stall` = 0, one bubble, and the count unchanged.
- `stall_ext` high for 3 cycles mid-stream. All stage outputs hold and `stall_count` rises by 3. Then `rst_n` = 0 for 1 cycle, after which every output is 0.

Source files
------------

// File: rtl/controle_pipeline_pkg.sv
// Shared opcode constants, control-field encodings and stage bundle types
// for the RV32 reduced-ISA control pipeline.
package controle_pipeline_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_ITYPE = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        REGALU = 2'b00,
        REGMEM = 2'b01,
        RPC    = 2'b10,
        REGIMM = 2'b11
    } mem2reg_e;

    typedef enum logic [1:0] {
        BCN    = 2'b00,
        BCB    = 2'b01,
        BCJAL  = 2'b10,
        BCJALR = 2'b11
    } branch_e;

    // Full bundle as decoded in ID and held in ID/EX
    typedef struct packed {
        logic     alusrc;
        logic     alusrc_a;
        aluop_e   aluop;
        logic     memread;
        logic     memwrite;
        branch_e  branch;
        logic     regwrite;
        mem2reg_e mem2reg;
    } ctl_t;

    // Fields still needed once the instruction has left EX
    typedef struct packed {
        logic     memread;
        logic     memwrite;
        branch_e  branch;
        logic     regwrite;
        mem2reg_e mem2reg;
    } mem_ctl_t;

    // Fields still needed once the instruction has left MEM
    typedef struct packed {
        logic     regwrite;
        mem2reg_e mem2reg;
    } wb_ctl_t;

    localparam ctl_t CTL_BUBBLE = '0;

endpackage

// File: rtl/controle_pipeline_if.sv
// Signal bundle between the IF/ID side, the datapath stage registers and the
// control pipeline. The slave modport is the control pipeline's view.
interface controle_pipeline_if #(
    parameter int CNTW = 16
);
    logic            id_valid;
    logic [6:0]      id_opcode;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            stall_ext;
    logic            flush_ex;
    logic            hazard_stall;
    logic            id_illegal;
    logic            ex_valid;
    logic            ex_alusrc;
    logic            ex_alusrc_a;
    logic [1:0]      ex_aluop;
    logic [4:0]      ex_rd;
    logic            mem_valid;
    logic            mem_memread;
    logic            mem_memwrite;
    logic [1:0]      mem_branch;
    logic [4:0]      mem_rd;
    logic            wb_valid;
    logic            wb_regwrite;
    logic [1:0]      wb_mem2reg;
    logic [4:0]      wb_rd;
    logic [CNTW-1:0] stall_count;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, stall_ext, flush_ex,
        input  hazard_stall, id_illegal,
        input  ex_valid, ex_alusrc, ex_alusrc_a, ex_aluop, ex_rd,
        input  mem_valid, mem_memread, mem_memwrite, mem_branch, mem_rd,
        input  wb_valid, wb_regwrite, wb_mem2reg, wb_rd,
        input  stall_count
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, stall_ext, flush_ex,
        output hazard_stall, id_illegal,
        output ex_valid, ex_alusrc, ex_alusrc_a, ex_aluop, ex_rd,
        output mem_valid, mem_memread, mem_memwrite, mem_branch, mem_rd,
        output wb_valid, wb_regwrite, wb_mem2reg, wb_rd,
        output stall_count
    );

endinterface

// File: rtl/controle_pipeline_decode.sv
// Combinational opcode-to-control-bundle decoder with register-use flags
// and illegal-opcode detection. Invalid or illegal slots decode to a bubble.
module controle_decode
    import controle_pipeline_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    output ctl_t       ctl,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       illegal
);

    logic known;

    // Opcode table; anything unmatched or not valid collapses to a bubble
    always_comb begin
        ctl      = CTL_BUBBLE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        known    = 1'b1;
        case (id_opcode)
            OP_R: begin
                ctl.aluop    = ALU_RTYPE;
                ctl.regwrite = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_LOAD: begin
                ctl.alusrc   = 1'b1;
                ctl.memread  = 1'b1;
                ctl.regwrite = 1'b1;
                ctl.mem2reg  = REGMEM;
                uses_rs1     = 1'b1;
            end
            OP_STORE: begin
                ctl.alusrc   = 1'b1;
                ctl.memwrite = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_BRANCH: begin
                ctl.aluop    = ALU_SUB;
                ctl.branch   = BCB;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_IMM: begin
                ctl.alusrc   = 1'b1;
                ctl.aluop    = ALU_ITYPE;
                ctl.regwrite = 1'b1;
                uses_rs1     = 1'b1;
            end
            OP_JALR: begin
                ctl.alusrc   = 1'b1;
                ctl.branch   = BCJALR;
                ctl.regwrite = 1'b1;
                ctl.mem2reg  = RPC;
                uses_rs1     = 1'b1;
            end
            OP_JAL: begin
                ctl.branch   = BCJAL;
                ctl.regwrite = 1'b1;
                ctl.mem2reg  = RPC;
            end
            OP_LUI: begin
                ctl.alusrc   = 1'b1;
                ctl.regwrite = 1'b1;
                ctl.mem2reg  = REGIMM;
                known        = (EXT_OPS != 0);
            end
            OP_AUIPC: begin
                ctl.alusrc   = 1'b1;
                ctl.alusrc_a = 1'b1;
                ctl.regwrite = 1'b1;
                known        = (EXT_OPS != 0);
            end
            default: known = 1'b0;
        endcase
        if (!(id_valid && known)) begin
            ctl      = CTL_BUBBLE;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end
    end

    assign illegal = id_valid & ~known;

endmodule

// File: rtl/controle_pipeline.sv
// Registered control pipeline: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers with valid bits, load-use hazard detection, bubble insertion,
// external freeze and a saturating stall-cycle counter.
module controle_pipeline
    import controle_pipeline_pkg::*;
#(
    parameter int EXT_OPS        = 1,
    parameter int LOADUSE_DETECT = 1,
    parameter int CNTW           = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    controle_pipeline_if.slave bus
);

    ctl_t            ctl_p0;
    logic            uses_rs1_p0;
    logic            uses_rs2_p0;
    logic            illegal_p0;
    logic            load_use;

    ctl_t            ctl_p1;
    logic            vld_p1;
    logic [4:0]      rd_p1;
    mem_ctl_t        ctl_p2;
    logic            vld_p2;
    logic [4:0]      rd_p2;
    wb_ctl_t         ctl_p3;
    logic            vld_p3;
    logic [4:0]      rd_p3;
    logic [CNTW-1:0] cnt_q;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    controle_decode #(
        .EXT_OPS (EXT_OPS)
    ) u_decode (
        .id_valid  (bus.id_valid),
        .id_opcode (bus.id_opcode),
        .ctl       (ctl_p0),
        .uses_rs1  (uses_rs1_p0),
        .uses_rs2  (uses_rs2_p0),
        .illegal   (illegal_p0)
    );

    // A load in EX whose destination feeds the instruction in ID; x0 never hazards
    assign load_use = vld_p1 & ctl_p1.memread & (rd_p1 != 5'd0) & bus.id_valid &
                      (((rd_p1 == bus.id_rs1) & uses_rs1_p0) |
                       ((rd_p1 == bus.id_rs2) & uses_rs2_p0));

    // A redirect kills the ID instruction, so stalling it would be pointless
    assign bus.hazard_stall = (LOADUSE_DETECT != 0) & load_use & ~bus.flush_ex;
    assign bus.id_illegal   = illegal_p0;

    // Stage registers: reset clears all, stall_ext freezes all, else shift with bubble insertion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl_p1 <= CTL_BUBBLE;
            vld_p1 <= 1'b0;
            rd_p1  <= 5'd0;
            ctl_p2 <= '0;
            vld_p2 <= 1'b0;
            rd_p2  <= 5'd0;
            ctl_p3 <= '0;
            vld_p3 <= 1'b0;
            rd_p3  <= 5'd0;
        end else if (!bus.stall_ext) begin
            // ID -> EX
            if (bus.flush_ex || bus.hazard_stall || illegal_p0) begin
                ctl_p1 <= CTL_BUBBLE;
                vld_p1 <= 1'b0;
                rd_p1  <= 5'd0;
            end else begin
                ctl_p1 <= ctl_p0;
                vld_p1 <= bus.id_valid;
                rd_p1  <= bus.id_valid ? bus.id_rd : 5'd0;
            end
            // EX -> MEM
            ctl_p2.memread  <= ctl_p1.memread;
            ctl_p2.memwrite <= ctl_p1.memwrite;
            ctl_p2.branch   <= ctl_p1.branch;
            ctl_p2.regwrite <= ctl_p1.regwrite;
            ctl_p2.mem2reg  <= ctl_p1.mem2reg;
            vld_p2          <= vld_p1;
            rd_p2           <= rd_p1;
            // MEM -> WB
            ctl_p3.regwrite <= ctl_p2.regwrite;
            ctl_p3.mem2reg  <= ctl_p2.mem2reg;
            vld_p3          <= vld_p2;
            rd_p3           <= rd_p2;
        end
    end

    // Count every cycle the front end is held, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.hazard_stall || bus.stall_ext) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign bus.ex_valid     = vld_p1;
    assign bus.ex_alusrc    = ctl_p1.alusrc;
    assign bus.ex_alusrc_a  = ctl_p1.alusrc_a;
    assign bus.ex_aluop     = ctl_p1.aluop;
    assign bus.ex_rd        = rd_p1;
    assign bus.mem_valid    = vld_p2;
    assign bus.mem_memread  = ctl_p2.memread;
    assign bus.mem_memwrite = ctl_p2.memwrite;
    assign bus.mem_branch   = ctl_p2.branch;
    assign bus.mem_rd       = rd_p2;
    assign bus.wb_valid     = vld_p3;
    assign bus.wb_regwrite  = ctl_p3.regwrite;
    assign bus.wb_mem2reg   = ctl_p3.mem2reg;
    assign bus.wb_rd        = rd_p3;
    assign bus.stall_count  = cnt_q;

endmodule

// File: tb/tb_controle_pipeline.sv
// Directed testbench for controle_pipeline: stage latency, load-use stall,
// illegal opcodes (with and without LUI/AUIPC), flush priority, external
// freeze, stall counting and mid-run reset.
module tb_controle_pipeline;
    import controle_pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    controle_pipeline_if #(.CNTW(16)) bus ();
    controle_pipeline_if #(.CNTW(16)) bus0 ();

    controle_pipeline #(.EXT_OPS(1), .LOADUSE_DETECT(1), .CNTW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    controle_pipeline #(.EXT_OPS(0), .LOADUSE_DETECT(1), .CNTW(16)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    // The EXT_OPS=0 copy sees exactly the same ID-side stimulus
    assign bus0.id_valid  = bus.id_valid;
    assign bus0.id_opcode = bus.id_opcode;
    assign bus0.id_rs1    = bus.id_rs1;
    assign bus0.id_rs2    = bus.id_rs2;
    assign bus0.id_rd     = bus.id_rd;
    assign bus0.stall_ext = bus.stall_ext;
    assign bus0.flush_ex  = bus.flush_ex;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.stall_ext = 1'b0;
        bus.flush_ex  = 1'b0;
        drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_mem_valid", bus.mem_valid, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_count", bus.stall_count, 0);
        chk("rst_hazard", bus.hazard_stall, 0);
        rst_n = 1'b1;

        // Stream of all base opcodes, one per cycle
        drv(1'b1, OP_R, 5'd0, 5'd0, 5'd1);
        tick();
        chk("r_ex_valid", bus.ex_valid, 1);
        chk("r_ex_aluop", bus.ex_aluop, 2'b10);
        chk("r_ex_rd", bus.ex_rd, 1);
        drv(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd2);
        tick();
        chk("ld_ex_alusrc", bus.ex_alusrc, 1);
        chk("r_mem_valid", bus.mem_valid, 1);
        chk("r_mem_rd", bus.mem_rd, 1);
        drv(1'b1, OP_STORE, 5'd0, 5'd0, 5'd0);
        tick();
        chk("r_wb_valid", bus.wb_valid, 1);
        chk("r_wb_regwrite", bus.wb_regwrite, 1);
        chk("r_wb_rd", bus.wb_rd, 1);
        chk("ld_mem_memread", bus.mem_memread, 1);
        drv(1'b1, OP_BRANCH, 5'd0, 5'd0, 5'd0);
        tick();
        chk("ld_wb_mem2reg", bus.wb_mem2reg, 2'b01);
        chk("ld_wb_rd", bus.wb_rd, 2);
        chk("st_mem_memwrite", bus.mem_memwrite, 1);
        chk("br_ex_aluop", bus.ex_aluop, 2'b01);
        drv(1'b1, OP_IMM, 5'd0, 5'd0, 5'd3);
        tick();
        chk("br_mem_branch", bus.mem_branch, 2'b01);
        chk("imm_ex_aluop", bus.ex_aluop, 2'b11);
        chk("st_wb_regwrite", bus.wb_regwrite, 0);
        drv(1'b1, OP_JALR, 5'd0, 5'd0, 5'd4);
        tick();
        chk("jalr_ex_alusrc", bus.ex_alusrc, 1);
        chk("imm_mem_rd", bus.mem_rd, 3);
        drv(1'b1, OP_JAL, 5'd0, 5'd0, 5'd7);
        tick();
        chk("jal_ex_alusrc", bus.ex_alusrc, 0);
        chk("jalr_mem_branch", bus.mem_branch, 2'b11);
        drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("jal_mem_branch", bus.mem_branch, 2'b10);
        chk("jal_mem_rd", bus.mem_rd, 7);
        chk("idle_ex_valid", bus.ex_valid, 0);
        tick();
        chk("jal_wb_mem2reg", bus.wb_mem2reg, 2'b10);
        chk("jal_wb_regwrite", bus.wb_regwrite, 1);
        tick();
        tick();

        // lw x5 ; add x6,x5,x1
        drv(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
        tick();
        drv(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
        #1;
        chk("lu_hazard_on", bus.hazard_stall, 1);
        tick();
        chk("lu_bubble", bus.ex_valid, 0);
        chk("lu_mem_memread", bus.mem_memread, 1);
        chk("lu_mem_rd", bus.mem_rd, 5);
        chk("lu_hazard_off", bus.hazard_stall, 0);
        tick();
        chk("lu_add_ex_valid", bus.ex_valid, 1);
        chk("lu_add_ex_rd", bus.ex_rd, 6);
        chk("lu_count", bus.stall_count, 1);

        // lw x0 ; add x6,x0,x1  and  lw x5 ; jal
        drv(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0);
        tick();
        drv(1'b1, OP_R, 5'd0, 5'd1, 5'd6);
        #1;
        chk("x0_no_hazard", bus.hazard_stall, 0);
        tick();
        drv(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd5);
        tick();
        drv(1'b1, OP_JAL, 5'd5, 5'd5, 5'd1);
        #1;
        chk("jal_no_hazard", bus.hazard_stall, 0);
        tick();
        chk("nohz_count", bus.stall_count, 1);

        // Illegal opcode and LUI/AUIPC gating
        drv(1'b1, 7'b0000000, 5'd0, 5'd0, 5'd3);
        #1;
        chk("ill_flag", bus.id_illegal, 1);
        tick();
        chk("ill_bubble", bus.ex_valid, 0);
        drv(1'b0, 7'b0000000, 5'd0, 5'd0, 5'd3);
        #1;
        chk("ill_invalid", bus.id_illegal, 0);
        drv(1'b1, OP_LUI, 5'd0, 5'd0, 5'd8);
        #1;
        chk("lui_legal", bus.id_illegal, 0);
        chk("lui_noext_ill", bus0.id_illegal, 1);
        tick();
        chk("lui_ex_valid", bus.ex_valid, 1);
        chk("lui_ex_alusrc", bus.ex_alusrc, 1);
        chk("lui_noext_bubble", bus0.ex_valid, 0);
        drv(1'b1, OP_AUIPC, 5'd0, 5'd0, 5'd9);
        tick();
        chk("auipc_alusrc_a", bus.ex_alusrc_a, 1);
        chk("auipc_noext_bubble", bus0.ex_valid, 0);
        drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("lui_wb_mem2reg", bus.wb_mem2reg, 2'b11);
        chk("lui_wb_rd", bus.wb_rd, 8);
        tick();
        tick();

        // Flush coinciding with a load-use condition
        drv(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
        tick();
        drv(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
        bus.flush_ex = 1'b1;
        #1;
        chk("fl_hazard", bus.hazard_stall, 0);
        tick();
        chk("fl_bubble", bus.ex_valid, 0);
        chk("fl_count", bus.stall_count, 1);
        bus.flush_ex = 1'b0;
        drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();

        // External freeze for 3 cycles, then reset
        drv(1'b1, OP_R, 5'd0, 5'd0, 5'd9);
        tick();
        drv(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd10);
        tick();
        drv(1'b1, OP_IMM, 5'd0, 5'd0, 5'd11);
        tick();
        drv(1'b1, OP_STORE, 5'd0, 5'd0, 5'd0);
        bus.stall_ext = 1'b1;
        repeat (3) tick();
        chk("se_ex_valid", bus.ex_valid, 1);
        chk("se_ex_rd", bus.ex_rd, 11);
        chk("se_mem_rd", bus.mem_rd, 10);
        chk("se_mem_memread", bus.mem_memread, 1);
        chk("se_wb_rd", bus.wb_rd, 9);
        chk("se_wb_regwrite", bus.wb_regwrite, 1);
        chk("se_count", bus.stall_count, 4);
        bus.stall_ext = 1'b0;
        rst_n = 1'b0;
        drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("rr_ex_valid", bus.ex_valid, 0);
        chk("rr_ex_rd", bus.ex_rd, 0);
        chk("rr_mem_valid", bus.mem_valid, 0);
        chk("rr_mem_memread", bus.mem_memread, 0);
        chk("rr_wb_valid", bus.wb_valid, 0);
        chk("rr_wb_regwrite", bus.wb_regwrite, 0);
        chk("rr_count", bus.stall_count, 0);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
